// File: rtl/lsu_axi_master_pkg.sv
// Shared encodings for the LSU AXI4-Lite bus stage: access sizes, AXI response/prot codes, FSM states.
package lsu_axi_master_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    localparam logic [1:0] RESP_OKAY = 2'b00;
    localparam logic [2:0] PROT_DATA = 3'b000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_WR_B,
        ST_RD_A,
        ST_RD_D,
        ST_RESP
    } lsu_state_t;

    // Size 2'b11 is handled as a word access.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            SIZE_BYTE: is_misaligned = 1'b0;
            SIZE_HALF: is_misaligned = offset[0];
            default:   is_misaligned = (offset != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: store data replication + byte strobes, load lane extract + sign/zero extend.
module lsu_lane_align
    import lsu_axi_master_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic        is_unsigned,
    input  logic [31:0] store_data,
    input  logic [31:0] bus_rdata,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] load_data
);

    logic [1:0]  offset;
    logic [31:0] shifted;

    // NOTE: every output of a combinational block gets a default first so no path infers a latch.
    always_comb begin
        bus_wdata = store_data;
        bus_wstrb = 4'b1111;
        offset    = 2'b00;
        case (size)
            SIZE_BYTE: begin
                bus_wdata = {4{store_data[7:0]}};
                bus_wstrb = 4'b0001 << addr_lo;
                offset    = addr_lo;
            end
            SIZE_HALF: begin
                bus_wdata = {2{store_data[15:0]}};
                bus_wstrb = 4'b0011 << {addr_lo[1], 1'b0};
                offset    = {addr_lo[1], 1'b0};
            end
            default: ;
        endcase
    end

    assign shifted = bus_rdata >> {offset, 3'b000};

    always_comb begin
        load_data = shifted;
        case (size)
            SIZE_BYTE: load_data = {{24{~is_unsigned & shifted[7]}}, shifted[7:0]};
            SIZE_HALF: load_data = {{16{~is_unsigned & shifted[15]}}, shifted[15:0]};
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu_axi_master.sv
// LSU bus stage: one load/store at a time as a single AXI4-Lite transaction.
// Optional LSU_MISALIGN_CHECK_EN: misaligned half/word accesses complete with an error and no bus traffic.
module lsu_axi_master
    import lsu_axi_master_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic [2:0]            m_axi_awprot,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    output logic [31:0]           m_axi_wdata,
    output logic [3:0]            m_axi_wstrb,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,
    input  logic [1:0]            m_axi_bresp,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [2:0]            m_axi_arprot,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,
    input  logic [31:0]           m_axi_rdata,
    input  logic [1:0]            m_axi_rresp
);

    lsu_state_t            state_q, state_d;
    logic [1:0]            size_q;
    logic                  unsigned_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           wdata_q;
    logic                  aw_done_q, w_done_q;
    logic [31:0]           rdata_q;
    logic                  err_q;
    logic                  accept, misaligned;
    logic [31:0]           load_data;

`ifdef LSU_MISALIGN_CHECK_EN
    assign misaligned = is_misaligned(req_size, req_addr[1:0]);
`else
    assign misaligned = 1'b0;
`endif

    assign accept = req_valid & req_ready;

    lsu_lane_align u_lane_align (
        .size        (size_q),
        .addr_lo     (addr_q[1:0]),
        .is_unsigned (unsigned_q),
        .store_data  (wdata_q),
        .bus_rdata   (m_axi_rdata),
        .bus_wdata   (m_axi_wdata),
        .bus_wstrb   (m_axi_wstrb),
        .load_data   (load_data)
    );

    assign m_axi_awaddr = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    assign m_axi_araddr = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    assign m_axi_awprot = PROT_DATA;
    assign m_axi_arprot = PROT_DATA;
    assign resp_rdata   = rdata_q;
    assign resp_err     = err_q;

    always_comb begin
        state_d       = state_q;
        req_ready     = 1'b0;
        resp_valid    = 1'b0;
        m_axi_awvalid = 1'b0;
        m_axi_wvalid  = 1'b0;
        m_axi_bready  = 1'b0;
        m_axi_arvalid = 1'b0;
        m_axi_rready  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready = ~reset;
                if (req_valid && !reset)
                    state_d = misaligned ? ST_RESP : (req_we ? ST_WR : ST_RD_A);
            end
            ST_WR: begin
                // AW and W complete independently; leave once both have handshaken.
                m_axi_awvalid = ~aw_done_q;
                m_axi_wvalid  = ~w_done_q;
                if ((aw_done_q || m_axi_awready) && (w_done_q || m_axi_wready))
                    state_d = ST_WR_B;
            end
            ST_WR_B: begin
                m_axi_bready = 1'b1;
                if (m_axi_bvalid) state_d = ST_RESP;
            end
            ST_RD_A: begin
                m_axi_arvalid = 1'b1;
                if (m_axi_arready) state_d = ST_RD_D;
            end
            ST_RD_D: begin
                m_axi_rready = 1'b1;
                if (m_axi_rvalid) state_d = ST_RESP;
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values regardless of block order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rdata_q   <= 32'h0;
            err_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                aw_done_q <= 1'b0;
                w_done_q  <= 1'b0;
                rdata_q   <= 32'h0;
                err_q     <= misaligned;
            end
            if (m_axi_awvalid && m_axi_awready) aw_done_q <= 1'b1;
            if (m_axi_wvalid && m_axi_wready)   w_done_q  <= 1'b1;
            if (m_axi_bvalid && m_axi_bready)   err_q     <= (m_axi_bresp != RESP_OKAY);
            if (m_axi_rvalid && m_axi_rready) begin
                rdata_q <= load_data;
                err_q   <= (m_axi_rresp != RESP_OKAY);
            end
        end
    end

    // NOTE: request payload is not reset; it is only observed after an accept has loaded it.
    always_ff @(posedge clk) begin
        if (accept) begin
            size_q     <= req_size;
            unsigned_q <= req_unsigned;
            addr_q     <= req_addr;
            wdata_q    <= req_wdata;
        end
    end

endmodule

// File: tb/tb_lsu_axi_master.sv
// Scoreboard bench for lsu_axi_master: expected AXI beats and responses are queued at issue and
// popped by independent slave/response monitors. Expectations follow LSU_MISALIGN_CHECK_EN.
module tb_lsu_axi_master;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0, req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;

    always #5 clk = ~clk;

    lsu_axi_master #(.ADDR_WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .m_axi_awvalid(awvalid), .m_axi_awready(awready), .m_axi_awaddr(awaddr), .m_axi_awprot(awprot),
        .m_axi_wvalid(wvalid), .m_axi_wready(wready), .m_axi_wdata(wdata), .m_axi_wstrb(wstrb),
        .m_axi_bvalid(bvalid), .m_axi_bready(bready), .m_axi_bresp(bresp),
        .m_axi_arvalid(arvalid), .m_axi_arready(arready), .m_axi_araddr(araddr), .m_axi_arprot(arprot),
        .m_axi_rvalid(rvalid), .m_axi_rready(rready), .m_axi_rdata(rdata), .m_axi_rresp(rresp)
    );

    typedef struct { logic [31:0] rdata; logic err; int lat; } resp_t;
    typedef struct { logic [31:0] data; logic [3:0] strb; } wbeat_t;

    resp_t       resp_q[$];
    logic [31:0] aw_q[$];
    wbeat_t      w_q[$];
    logic [31:0] ar_q[$];

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    int accept_cyc = 0;

    // Slave behaviour knobs, changed only while the bus is idle.
    int          aw_dly = 0, w_dly = 0, ar_dly = 0;
    bit          b_hold = 1'b0;
    logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
    logic [31:0] rdata_cfg = 32'h0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // AXI4-Lite slave model + per-channel checker.
    bit sv_aw, sv_w, sv_ar, hs_aw, hs_w, hs_b, hs_ar, hs_r;
    bit aw_pend = 1'b0, w_pend = 1'b0, ar_pend = 1'b0, aw_ok = 1'b0, w_ok = 1'b0;
    int aw_wait = 0, w_wait = 0, ar_wait = 0;
    logic [31:0] exp_addr;
    wbeat_t      exp_w;

    initial begin
        awready = 1'b1; wready = 1'b1; arready = 1'b1;
        bvalid = 1'b0; bresp = 2'b00; rvalid = 1'b0; rresp = 2'b00; rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (aw_pend) check("awvalid_hold", {31'b0, awvalid}, 32'd1);
                if (w_pend)  check("wvalid_hold",  {31'b0, wvalid},  32'd1);
                if (ar_pend) check("arvalid_hold", {31'b0, arvalid}, 32'd1);
            end
            sv_aw = awvalid; sv_w = wvalid; sv_ar = arvalid;
            hs_aw = awvalid && awready; hs_w = wvalid && wready; hs_ar = arvalid && arready;
            hs_b  = bvalid && bready;   hs_r = rvalid && rready;
            if (hs_aw) begin
                if (aw_q.size() == 0) check("aw_unexpected", 32'd1, 32'd0);
                else begin
                    exp_addr = aw_q.pop_front();
                    check("awaddr", awaddr, exp_addr);
                    check("awprot", {29'b0, awprot}, 32'd0);
                end
            end
            if (hs_w) begin
                if (w_q.size() == 0) check("w_unexpected", 32'd1, 32'd0);
                else begin
                    exp_w = w_q.pop_front();
                    check("wdata", wdata, exp_w.data);
                    check("wstrb", {28'b0, wstrb}, {28'b0, exp_w.strb});
                end
            end
            if (hs_ar) begin
                if (ar_q.size() == 0) check("ar_unexpected", 32'd1, 32'd0);
                else begin
                    exp_addr = ar_q.pop_front();
                    check("araddr", araddr, exp_addr);
                    check("arprot", {29'b0, arprot}, 32'd0);
                end
            end
            aw_pend = awvalid && !awready && !reset;
            w_pend  = wvalid && !wready && !reset;
            ar_pend = arvalid && !arready && !reset;

            @(posedge clk);
            #1;
            if (reset) begin
                aw_ok = 1'b0; w_ok = 1'b0; aw_wait = 0; w_wait = 0; ar_wait = 0;
                awready = (aw_dly == 0); wready = (w_dly == 0); arready = (ar_dly == 0);
                bvalid = 1'b0; rvalid = 1'b0;
            end else begin
                if (hs_aw) begin aw_ok = 1'b1; aw_wait = 0; awready = (aw_dly == 0); end
                else if (sv_aw) begin aw_wait++; awready = (aw_wait >= aw_dly); end
                else begin aw_wait = 0; awready = (aw_dly == 0); end
                if (hs_w) begin w_ok = 1'b1; w_wait = 0; wready = (w_dly == 0); end
                else if (sv_w) begin w_wait++; wready = (w_wait >= w_dly); end
                else begin w_wait = 0; wready = (w_dly == 0); end
                if (hs_r) rvalid = 1'b0;
                if (hs_ar) begin
                    ar_wait = 0; arready = (ar_dly == 0);
                    rvalid = 1'b1; rdata = rdata_cfg; rresp = rresp_cfg;
                end
                else if (sv_ar) begin ar_wait++; arready = (ar_wait >= ar_dly); end
                else begin ar_wait = 0; arready = (ar_dly == 0); end
                if (hs_b) bvalid = 1'b0;
                if (aw_ok && w_ok && !b_hold) begin
                    bvalid = 1'b1; bresp = bresp_cfg; aw_ok = 1'b0; w_ok = 1'b0;
                end
            end
        end
    end

    // Response monitor.
    resp_t got_exp;
    initial begin
        forever begin
            @(negedge clk);
            if (resp_valid) begin
                if (resp_q.size() == 0) check("resp_unexpected", 32'd1, 32'd0);
                else begin
                    got_exp = resp_q.pop_front();
                    check("resp_rdata", resp_rdata, got_exp.rdata);
                    check("resp_err", {31'b0, resp_err}, {31'b0, got_exp.err});
                    check("resp_latency", cyc - accept_cyc, got_exp.lat);
                end
            end
        end
    end

    task automatic exp_store(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        wbeat_t b;
        b.data = data; b.strb = strb;
        aw_q.push_back(addr);
        w_q.push_back(b);
    endtask

    task automatic do_req(input bit we, input logic [1:0] size, input bit uns, input logic [31:0] addr,
                          input logic [31:0] data, input bit push_resp, input logic [31:0] exp_rdata,
                          input bit exp_err, input int exp_lat);
        resp_t r;
        bit    accepted = 1'b0;
        if (push_resp) begin
            r.rdata = exp_rdata; r.err = exp_err; r.lat = exp_lat;
            resp_q.push_back(r);
        end
        @(posedge clk);
        #1;
        req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = data;
        req_valid = 1'b1;
        for (int i = 0; i < 50 && !accepted; i++) begin
            @(negedge clk);
            if (req_ready) begin accepted = 1'b1; accept_cyc = cyc; end
        end
        if (!accepted) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 100 && resp_q.size() != 0; i++) @(negedge clk);
        if (resp_q.size() != 0) begin
            check({name, "_resp_timeout"}, resp_q.size(), 32'd0);
            resp_q.delete();
        end
        check({name, "_axi_left"}, aw_q.size() + w_q.size() + ar_q.size(), 32'd0);
        aw_q.delete(); w_q.delete(); ar_q.delete();
        repeat (2) @(posedge clk);
    endtask

    initial begin
        bit seen_b;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", {31'b0, req_ready}, 32'd0);
        check("rst_valids", {26'b0, awvalid, wvalid, bready, arvalid, rready, resp_valid}, 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_resp_err", {31'b0, resp_err}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("idle_req_ready", {31'b0, req_ready}, 32'd1);

        // Word store, always-ready slave: minimum latency.
        exp_store(32'h8000_0004, 32'hDEAD_BEEF, 4'b1111);
        do_req(1, 2'b10, 0, 32'h8000_0004, 32'hDEAD_BEEF, 1, 32'h0, 0, 3);
        wait_done("sw");

        // Byte store, AW delayed two cycles past W.
        aw_dly = 2;
        exp_store(32'h8000_0000, 32'hA5A5_A5A5, 4'b1000);
        do_req(1, 2'b00, 0, 32'h8000_0003, 32'h0000_00A5, 1, 32'h0, 0, 5);
        wait_done("sb_split");
        aw_dly = 0;

        exp_store(32'h8000_0004, 32'hBEEF_BEEF, 4'b1100);
        do_req(1, 2'b01, 0, 32'h8000_0006, 32'h0000_BEEF, 1, 32'h0, 0, 3);
        wait_done("sh_hi");
        exp_store(32'h8000_0000, 32'h5A5A_5A5A, 4'b0001);
        do_req(1, 2'b00, 0, 32'h8000_0000, 32'hFFFF_FF5A, 1, 32'h0, 0, 3);
        wait_done("sb_lo");

        // Loads against rdata 0x1234_80FF.
        rdata_cfg = 32'h1234_80FF;
        ar_q.push_back(32'h8000_0000);
        do_req(0, 2'b00, 0, 32'h8000_0001, 32'h0, 1, 32'hFFFF_FF80, 0, 3);
        wait_done("lb");
        ar_q.push_back(32'h8000_0000);
        do_req(0, 2'b00, 1, 32'h8000_0001, 32'h0, 1, 32'h0000_0080, 0, 3);
        wait_done("lbu");
        ar_q.push_back(32'h8000_0000);
        do_req(0, 2'b01, 0, 32'h8000_0002, 32'h0, 1, 32'h0000_1234, 0, 3);
        wait_done("lh_hi");
        ar_q.push_back(32'h8000_0000);
        do_req(0, 2'b01, 1, 32'h8000_0000, 32'h0, 1, 32'h0000_80FF, 0, 3);
        wait_done("lhu_lo");
        ar_q.push_back(32'h8000_0000);
        do_req(0, 2'b01, 0, 32'h8000_0000, 32'h0, 1, 32'hFFFF_80FF, 0, 3);
        wait_done("lh_lo");
        ar_q.push_back(32'h8000_0000);
        do_req(0, 2'b00, 0, 32'h8000_0003, 32'h0, 1, 32'h0000_0012, 0, 3);
        wait_done("lb_b3");
        ar_q.push_back(32'h8000_0008);
        do_req(0, 2'b11, 0, 32'h8000_0008, 32'h0, 1, 32'h1234_80FF, 0, 3);
        wait_done("lw_size11");

        // Bus errors and a slow address channel.
        rdata_cfg = 32'hCAFE_F00D; rresp_cfg = 2'b10;
        ar_q.push_back(32'h8000_0010);
        do_req(0, 2'b10, 0, 32'h8000_0010, 32'h0, 1, 32'hCAFE_F00D, 1, 3);
        wait_done("lw_slverr");
        rresp_cfg = 2'b00; bresp_cfg = 2'b11;
        exp_store(32'h8000_0014, 32'h0000_0000, 4'b1111);
        do_req(1, 2'b10, 0, 32'h8000_0014, 32'h0, 1, 32'h0, 1, 3);
        wait_done("sw_decerr");
        bresp_cfg = 2'b00;
        ar_dly = 5; rdata_cfg = 32'h0BAD_F00D;
        ar_q.push_back(32'h8000_0018);
        do_req(0, 2'b10, 0, 32'h8000_0018, 32'h0, 1, 32'h0BAD_F00D, 0, 8);
        wait_done("lw_ar_slow");
        ar_dly = 0;

        // Half load at an odd address.
        rdata_cfg = 32'h1234_80FF;
`ifdef LSU_MISALIGN_CHECK_EN
        do_req(0, 2'b01, 0, 32'h8000_0001, 32'h0, 1, 32'h0, 1, 1);
`else
        ar_q.push_back(32'h8000_0000);
        do_req(0, 2'b01, 0, 32'h8000_0001, 32'h0, 1, 32'hFFFF_80FF, 0, 3);
`endif
        wait_done("lh_odd");

        // Reset while waiting in WR_B with bvalid held low.
        b_hold = 1'b1;
        exp_store(32'h8000_0020, 32'h1122_3344, 4'b1111);
        do_req(1, 2'b10, 0, 32'h8000_0020, 32'h1122_3344, 0, 32'h0, 0, 0);
        seen_b = 1'b0;
        for (int i = 0; i < 20 && !seen_b; i++) begin
            @(negedge clk);
            if (bready) seen_b = 1'b1;
        end
        check("reached_wr_b", {31'b0, seen_b}, 32'd1);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_valids", {26'b0, awvalid, wvalid, bready, arvalid, rready, resp_valid}, 32'd0);
        check("midrst_req_ready", {31'b0, req_ready}, 32'd0);
        b_hold = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("postrst_req_ready", {31'b0, req_ready}, 32'd1);
        aw_q.delete(); w_q.delete();

        rdata_cfg = 32'h55AA_33CC;
        ar_q.push_back(32'h8000_0010);
        do_req(0, 2'b10, 0, 32'h8000_0010, 32'h0, 1, 32'h55AA_33CC, 0, 3);
        wait_done("lw_after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
